// File: rtl/object_update_scheduler.sv
// Per-frame sequencer that walks the enabled object slots and issues one update
// request per slot to a single shared physics unit, with done timeout and overrun tracking.
`timescale 1ns/1ps
module object_update_scheduler #(
  parameter int NUM_OBJECTS = 12,
  parameter int IDX_WIDTH   = 4,
  parameter int Y_DISPLAY   = 480,
  parameter int FRAME_DIV   = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pause,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [NUM_OBJECTS-1:0] enable_mask,
  input  logic                   upd_ready,
  input  logic                   upd_done,
  output logic                   upd_valid,
  output logic [IDX_WIDTH-1:0]   upd_idx,
  output logic                   frame_tick,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             overrun_count,
  output logic [7:0]             timeout_count,
  output logic [9:0]             LED,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, NEXT} state_t;

  localparam logic [9:0]           Y_LINE   = 10'(Y_DISPLAY);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OBJECTS - 1);
  localparam logic [7:0]           DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [7:0]           TO_LAST  = 8'(TIMEOUT - 1);

  state_t               state;
  logic [IDX_WIDTH-1:0] idx;
  logic [7:0]           frame_cnt;
  logic [7:0]           wait_cnt;
  logic                 fs_cond_d;
  logic                 fs_cond;
  logic                 fs;

  // Rising edge of the blanking-start condition, so a long x==0 hold yields one frame start.
  assign fs_cond = (x == 10'd0) && (y == Y_LINE);
  assign fs      = fs_cond & ~fs_cond_d;

  // Request handshake: upd_valid rises on entry to REQ and holds with upd_idx
  // unchanged until the cycle upd_valid && upd_ready, which is the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      frame_cnt     <= '0;
      wait_cnt      <= '0;
      fs_cond_d     <= 1'b0;
      frame_tick    <= 1'b0;
      upd_valid     <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
      timeout_count <= '0;
    end else begin
      fs_cond_d  <= fs_cond;
      frame_tick <= fs;
      if (fs && state != IDLE) begin
        overrun <= 1'b1;
        if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (fs && !pause) begin
            if (frame_cnt == DIV_LAST) begin
              frame_cnt <= '0;
              idx       <= '0;
              state     <= SCAN;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        SCAN: begin
          if (pause) begin
            state <= IDLE;
          end else if (enable_mask[idx]) begin
            upd_valid <= 1'b1;
            state     <= REQ;
          end else if (idx == LAST_IDX) begin
            state <= IDLE;
          end else begin
            idx <= idx + IDX_WIDTH'(1);
          end
        end
        REQ: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (upd_done) begin
            state <= NEXT;
          end else if (wait_cnt == TO_LAST) begin
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            state <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
          end else begin
            idx   <= idx + IDX_WIDTH'(1);
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign upd_idx   = idx;
  assign LED       = {busy, overrun, overrun_count};
  assign state_dbg = state;

endmodule

// File: tb/tb_object_update_scheduler.sv
// Directed bench for object_update_scheduler: one task per scenario, inline checks,
// a second instance with FRAME_DIV=2 for the pause/frame-division scenario.
`timescale 1ns/1ps
module tb_object_update_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic [9:0]  x = 10'd1;
  logic [9:0]  y = 10'd0;
  logic [11:0] enable_mask = 12'hFFF;
  logic        upd_ready = 1'b0;
  logic        upd_done = 1'b0;
  logic        auto_done = 1'b0;

  logic        upd_valid, frame_tick, busy, overrun;
  logic [3:0]  upd_idx;
  logic [7:0]  overrun_count, timeout_count;
  logic [9:0]  led;
  logic [2:0]  state_dbg;

  logic        b_upd_valid, b_frame_tick, b_busy, b_overrun;
  logic [3:0]  b_upd_idx;
  logic [7:0]  b_overrun_count, b_timeout_count;
  logic [9:0]  b_led;
  logic [2:0]  b_state_dbg;

  logic [3:0]  exp_q[$];
  logic [3:0]  got_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  object_update_scheduler #(.NUM_OBJECTS(12), .IDX_WIDTH(4), .Y_DISPLAY(480),
                            .FRAME_DIV(1), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .pause(pause), .x(x), .y(y), .enable_mask(enable_mask),
    .upd_ready(upd_ready), .upd_done(upd_done), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .frame_tick(frame_tick), .busy(busy), .overrun(overrun), .overrun_count(overrun_count),
    .timeout_count(timeout_count), .LED(led), .state_dbg(state_dbg)
  );

  object_update_scheduler #(.NUM_OBJECTS(12), .IDX_WIDTH(4), .Y_DISPLAY(480),
                            .FRAME_DIV(2), .TIMEOUT(10)) dut2 (
    .clk(clk), .reset(reset), .pause(pause), .x(x), .y(y), .enable_mask(enable_mask),
    .upd_ready(upd_ready), .upd_done(upd_done), .upd_valid(b_upd_valid), .upd_idx(b_upd_idx),
    .frame_tick(b_frame_tick), .busy(b_busy), .overrun(b_overrun), .overrun_count(b_overrun_count),
    .timeout_count(b_timeout_count), .LED(b_led), .state_dbg(b_state_dbg)
  );

  // clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle; the physics-unit model raises done in the cycle after a grant when auto_done is set.
  task automatic step();
    logic g;
    g = auto_done && upd_valid && upd_ready;
    @(posedge clk); #1;
    upd_done = g;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step();
    reset = 1'b0; x = 10'd1; y = 10'd0; pause = 1'b0;
    step();
  endtask

  task automatic fs_start();
    x = 10'd0; y = 10'd480;
    step();
    x = 10'd1;
  endtask

  // Counts busy cycles from now until busy drops (bounded) and records granted indices.
  task automatic run_until_idle(input bit sel, input int bound, output int cycles, output int ticks);
    logic b, t, v;
    logic [3:0] ix;
    got_q.delete();
    cycles = 0; ticks = 0;
    while (cycles < bound) begin
      b  = sel ? b_busy : busy;
      t  = sel ? b_frame_tick : frame_tick;
      v  = sel ? b_upd_valid : upd_valid;
      ix = sel ? b_upd_idx : upd_idx;
      if (!b) break;
      cycles++;
      if (t) ticks++;
      if (v && upd_ready) got_q.push_back(ix);
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step();
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", upd_valid); end
    n_checks++; if (upd_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", upd_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (led !== 10'd0) begin n_fail++; $display("FAIL reset_led: got %0h expected 0", led); end
    n_checks++; if (timeout_count !== 8'd0) begin n_fail++; $display("FAIL reset_tocnt: got %0d expected 0", timeout_count); end
    reset = 1'b0; step();
  endtask

  task automatic test_full_pass();
    int cyc, ticks;
    enable_mask = 12'hFFF; upd_ready = 1'b1; auto_done = 1'b1;
    x = 10'd0; y = 10'd480;
    step();  // T+1, x held at 0 through the pass
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL full_tick_t1: got %0b expected 1", frame_tick); end
    n_checks++; if (busy !== 1'b1 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL full_t1: busy %0b valid %0b expected 1 0", busy, upd_valid); end
    step();  // T+2
    n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 4'd0) begin n_fail++; $display("FAIL full_valid_t2: valid %0b idx %0d expected 1 0", upd_valid, upd_idx); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL full_tick_t2: got %0b expected 0", frame_tick); end
    run_until_idle(1'b0, 200, cyc, ticks);
    x = 10'd1;
    n_checks++; if (cyc + 1 !== 48) begin n_fail++; $display("FAIL full_busy_cycles: got %0d expected 48", cyc + 1); end
    n_checks++; if (ticks !== 0) begin n_fail++; $display("FAIL full_single_tick: extra ticks %0d expected 0", ticks); end
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(4'(i));
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_grant_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_order[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (timeout_count !== 8'd0) begin n_fail++; $display("FAIL full_no_timeout: got %0d expected 0", timeout_count); end
  endtask

  task automatic test_sparse_mask();
    int cyc, ticks;
    do_reset();
    enable_mask = 12'b1000_0000_0001; upd_ready = 1'b1; auto_done = 1'b1;
    fs_start();
    run_until_idle(1'b0, 200, cyc, ticks);
    n_checks++; if (cyc !== 18) begin n_fail++; $display("FAIL sparse_cycles: got %0d expected 18", cyc); end
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL sparse_count: got %0d expected 2", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== 4'd0 || got_q[1] !== 4'd11) begin n_fail++; $display("FAIL sparse_idx: got %0d,%0d expected 0,11", got_q[0], got_q[1]); end
    end
  endtask

  task automatic test_ready_stall();
    int k, cyc, ticks, bad;
    do_reset();
    enable_mask = 12'h020; upd_ready = 1'b0; auto_done = 1'b1;
    fs_start();
    k = 0;
    while (!upd_valid && k < 20) begin step(); k++; end
    n_checks++; if (k !== 6) begin n_fail++; $display("FAIL stall_latency: got %0d expected 6", k); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (upd_valid !== 1'b1 || upd_idx !== 4'd5) begin n_fail++; bad++; $display("FAIL stall_hold[%0d]: valid %0b idx %0d expected 1 5", i, upd_valid, upd_idx); end
      step();
    end
    upd_ready = 1'b1;
    n_checks++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid21: got %0b expected 1", upd_valid); end
    step();
    n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_grant: valid %0b expected 0", upd_valid); end
    run_until_idle(1'b0, 50, cyc, ticks);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL stall_tail: got %0d expected 8", cyc); end
  endtask

  task automatic test_timeout();
    int cyc, ticks;
    do_reset();
    enable_mask = 12'hFFF; upd_ready = 1'b1; auto_done = 1'b0;
    fs_start();
    run_until_idle(1'b0, 400, cyc, ticks);
    n_checks++; if (cyc !== 156) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 156", cyc); end
    n_checks++; if (timeout_count !== 8'd12) begin n_fail++; $display("FAIL timeout_count: got %0d expected 12", timeout_count); end
    n_checks++; if (got_q.size() !== 12) begin n_fail++; $display("FAIL timeout_grants: got %0d expected 12", got_q.size()); end
  endtask

  task automatic test_overrun();
    int n, cyc, ticks;
    do_reset();
    enable_mask = 12'hFFF; upd_ready = 1'b1; auto_done = 1'b1;
    fs_start();  // at T+1
    n = 0;
    for (int i = 0; i < 10; i++) begin if (busy) n++; step(); end
    if (busy) n++;  // T+11 carries the second frame start
    x = 10'd0; y = 10'd480;
    step();
    x = 10'd1;
    n_checks++; if (overrun !== 1'b1 || overrun_count !== 8'd1) begin n_fail++; $display("FAIL overrun_flag: ovr %0b cnt %0d expected 1 1", overrun, overrun_count); end
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL overrun_tick: got %0b expected 1", frame_tick); end
    n_checks++; if (led !== 10'h301) begin n_fail++; $display("FAIL overrun_led: got %0h expected 301", led); end
    run_until_idle(1'b0, 200, cyc, ticks);
    n_checks++; if (n + cyc !== 48) begin n_fail++; $display("FAIL overrun_pass_len: got %0d expected 48", n + cyc); end
    step(); step(); step();
    n_checks++; if (busy !== 1'b0 || overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_after: busy %0b ovr %0b expected 0 1", busy, overrun); end
    // stall in REQ, then hammer frame starts
    upd_ready = 1'b0;
    fs_start(); step();
    for (int i = 1; i <= 300; i++) begin
      x = 10'd0; step(); x = 10'd1; step();
      if (i == 253) begin
        n_checks++; if (overrun_count !== 8'd254) begin n_fail++; $display("FAIL overrun_254: got %0d expected 254", overrun_count); end
      end
    end
    n_checks++; if (overrun_count !== 8'd255) begin n_fail++; $display("FAIL overrun_sat: got %0d expected 255", overrun_count); end
    n_checks++; if (led !== 10'h3FF) begin n_fail++; $display("FAIL overrun_sat_led: got %0h expected 3ff", led); end
  endtask

  task automatic test_pause();
    int cyc, ticks;
    do_reset();
    enable_mask = 12'hFFF; upd_ready = 1'b1; auto_done = 1'b0; pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fs_start();
      n_checks++; if (b_frame_tick !== 1'b1) begin n_fail++; $display("FAIL pause_tick[%0d]: got %0b expected 1", i, b_frame_tick); end
      step();
      n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL pause_nopass[%0d]: busy %0b expected 0", i, b_busy); end
    end
    pause = 1'b0;
    fs_start(); step();
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL pause_div_first: busy %0b expected 0", b_busy); end
    fs_start();
    n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL pause_div_second: busy %0b expected 1", b_busy); end
    step(); step(); step(); step();  // T+5, object 0 in WAIT
    pause = 1'b1;
    run_until_idle(1'b1, 100, cyc, ticks);
    pause = 1'b0;
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL pause_midpass: got %0d expected 10", cyc); end
    n_checks++; if (b_timeout_count !== 8'd1) begin n_fail++; $display("FAIL pause_wait_done: got %0d expected 1", b_timeout_count); end
    n_checks++; if (b_upd_idx !== 4'd1) begin n_fail++; $display("FAIL pause_idx_hold: got %0d expected 1", b_upd_idx); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    enable_mask = 12'h010; upd_ready = 1'b1; auto_done = 1'b0;
    fs_start(); step(); step();  // T+3
    fs_start();                  // T+4
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL rst_pre_overrun: got %0b expected 1", overrun); end
    for (int i = 0; i < 5; i++) step();  // T+9, in WAIT
    n_checks++; if (busy !== 1'b1 || upd_valid !== 1'b0 || upd_idx !== 4'd4) begin n_fail++; $display("FAIL rst_pre_wait: busy %0b valid %0b idx %0d expected 1 0 4", busy, upd_valid, upd_idx); end
    reset = 1'b1;
    step();
    n_checks++; if ({upd_valid, upd_idx, frame_tick, busy, overrun} !== 8'd0) begin n_fail++; $display("FAIL rst_mid_flags: got %0h expected 0", {upd_valid, upd_idx, frame_tick, busy, overrun}); end
    n_checks++; if (overrun_count !== 8'd0 || timeout_count !== 8'd0 || led !== 10'd0) begin n_fail++; $display("FAIL rst_mid_counts: ovr %0d to %0d led %0h expected 0", overrun_count, timeout_count, led); end
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_sparse_mask();
    test_ready_stall();
    test_timeout();
    test_overrun();
    test_pause();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
